sms_ahb_sram_ctrl: RTL

//  Per-bank AHB-lite slave to single-port SRAM macro controller; one instance per sms bank port.

---
 rtl/sms_ahb_sram_ctrl_if.sv | 25 ++
 rtl/sms_ahb_sram_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sms_ahb_sram_ctrl_if.sv
// AHB-lite slave-port signal bundle between the hmain0 fabric and one sms bank controller.
interface sms_ahb_sram_ctrl_if;
   logic [31:0] ahb_sms_haddr;
   logic [3:0]  ahb_sms_hprot;
   logic        ahb_sms_hsel;
   logic [2:0]  ahb_sms_hsize;
   logic [1:0]  ahb_sms_htrans;
   logic [31:0] ahb_sms_hwdata;
   logic        ahb_sms_hwrite;
   logic [31:0] sms_ahb_hrdata;
   logic        sms_ahb_hready;
   logic [1:0]  sms_ahb_hresp;

   modport slave (
      input  ahb_sms_haddr, ahb_sms_hprot, ahb_sms_hsel, ahb_sms_hsize,
             ahb_sms_htrans, ahb_sms_hwdata, ahb_sms_hwrite,
      output sms_ahb_hrdata, sms_ahb_hready, sms_ahb_hresp
   );

   modport master (
      output ahb_sms_haddr, ahb_sms_hprot, ahb_sms_hsel, ahb_sms_hsize,
             ahb_sms_htrans, ahb_sms_hwdata, ahb_sms_hwrite,
      input  sms_ahb_hrdata, sms_ahb_hready, sms_ahb_hresp
   );
endinterface

// File: rtl/sms_ahb_sram_ctrl.sv
// Per-bank AHB-lite to single-port SRAM controller: zero-wait reads, posted writes through a
// one-entry buffer with read-after-write byte forwarding.
module sms_ahb_sram_ctrl #(
   parameter int ADDR_W = 14
) (
   input  logic              pmu_sms_hclk,
   input  logic              pmu_sms_hrst_b,
   sms_ahb_sram_ctrl_if.slave ahb,
   output logic              sms_idle,
   output logic              sms_ram_cen,
   output logic [3:0]        sms_ram_wen,
   output logic [ADDR_W-1:0] sms_ram_addr,
   output logic [31:0]       sms_ram_din,
   input  logic [31:0]       ram_sms_dout
);

   logic              hready;
   logic              acc;
   logic              rd_acc;
   logic [ADDR_W-1:0] acc_addr;
   logic [3:0]        acc_be;

   logic              wdp_q;
   logic              rdp_q;
   logic [ADDR_W-1:0] dp_addr_q;
   logic [3:0]        dp_be_q;

   logic              buf_vld_q;
   logic [ADDR_W-1:0] buf_addr_q;
   logic [3:0]        buf_be_q;
   logic [31:0]       buf_data_q;
   logic              buf_hit_q;
   logic              buf_hit_d;

   logic [ADDR_W-1:0] ram_addr_q;
   logic [31:0]       ram_din_q;

   logic              do_drain;
   logic              do_direct;
   logic              capture;
   logic [31:0]       rd_merged;

   logic              unused_ok;
   assign unused_ok = &{1'b0, ahb.ahb_sms_hprot, ahb.ahb_sms_haddr[31:ADDR_W+2]};

   assign hready   = !(buf_vld_q && wdp_q);
   assign acc      = ahb.ahb_sms_hsel && ahb.ahb_sms_htrans[1] && hready;
   assign rd_acc   = acc && !ahb.ahb_sms_hwrite;
   assign acc_addr = ahb.ahb_sms_haddr[ADDR_W+1:2];

   always_comb begin
      case (ahb.ahb_sms_hsize)
         3'd0:    acc_be = 4'b0001 << ahb.ahb_sms_haddr[1:0];
         3'd1:    acc_be = ahb.ahb_sms_haddr[1] ? 4'hC : 4'h3;
         default: acc_be = 4'hF;
      endcase
   end

   // Buffer is not drained while a read is in its data phase, so forwarding sees a stable entry.
   assign do_drain  = !rd_acc && buf_vld_q && !rdp_q;
   assign do_direct = !rd_acc && !do_drain && wdp_q && hready;
   assign capture   = wdp_q && hready && (rd_acc || do_drain);

   assign buf_hit_d = capture ? (dp_addr_q == acc_addr)
                              : (buf_vld_q && (buf_addr_q == acc_addr));

   // SRAM port; nothing is issued during a reset cycle so an abandoned write never lands.
   always_comb begin
      sms_ram_cen  = 1'b1;
      sms_ram_wen  = 4'hF;
      sms_ram_addr = ram_addr_q;
      sms_ram_din  = ram_din_q;
      if (pmu_sms_hrst_b) begin
         if (rd_acc) begin
            sms_ram_cen  = 1'b0;
            sms_ram_addr = acc_addr;
         end else if (do_drain) begin
            sms_ram_cen  = 1'b0;
            sms_ram_wen  = ~buf_be_q;
            sms_ram_addr = buf_addr_q;
            sms_ram_din  = buf_data_q;
         end else if (do_direct) begin
            sms_ram_cen  = 1'b0;
            sms_ram_wen  = ~dp_be_q;
            sms_ram_addr = dp_addr_q;
            sms_ram_din  = ahb.ahb_sms_hwdata;
         end
      end
   end

   always_ff @(posedge pmu_sms_hclk) begin
      if (!pmu_sms_hrst_b) begin
         wdp_q      <= 1'b0;
         rdp_q      <= 1'b0;
         dp_addr_q  <= '0;
         dp_be_q    <= 4'h0;
         buf_vld_q  <= 1'b0;
         buf_addr_q <= '0;
         buf_be_q   <= 4'h0;
         buf_data_q <= 32'h0;
         buf_hit_q  <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= 32'h0;
      end else begin
         ram_addr_q <= sms_ram_addr;
         ram_din_q  <= sms_ram_din;
         if (hready) begin
            wdp_q <= acc && ahb.ahb_sms_hwrite;
            rdp_q <= rd_acc;
            if (acc) begin
               dp_addr_q <= acc_addr;
               dp_be_q   <= acc_be;
            end
         end
         if (capture) begin
            buf_vld_q  <= 1'b1;
            buf_addr_q <= dp_addr_q;
            buf_be_q   <= dp_be_q;
            buf_data_q <= ahb.ahb_sms_hwdata;
         end else if (do_drain) begin
            buf_vld_q <= 1'b0;
         end
         buf_hit_q <= rd_acc && buf_hit_d;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign rd_merged[8*gi +: 8] = (buf_hit_q && buf_be_q[gi]) ? buf_data_q[8*gi +: 8]
                                                               : ram_sms_dout[8*gi +: 8];
   end

   assign ahb.sms_ahb_hrdata = rdp_q ? rd_merged : 32'h0;
   assign ahb.sms_ahb_hready = hready;
   assign ahb.sms_ahb_hresp  = 2'b00;
   assign sms_idle = !buf_vld_q && !wdp_q && !rdp_q
                     && !(ahb.ahb_sms_hsel && ahb.ahb_sms_htrans[1]);

endmodule
